// File: rtl/filter_pkg.sv
// Shared types, constants and the output saturation helper for the
// time-multiplexed biquad filter.
package filter_pkg;

    localparam int FRAC_DEFAULT = 14;
    localparam int ACC_GUARD    = 3;
    localparam int NUM_COEF     = 5;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_MAC3 = 3'd4,
        ST_MAC4 = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Clamp a sign-extended value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/filter_coef_bank.sv
// Per-channel biquad coefficient registers (b0 resets to unity) with one
// write port and a five-word read of the selected channel.
module filter_coef_bank
    import filter_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int NCH    = 4,
    parameter int CH_W   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we_i,
    input  logic [CH_W-1:0]              wr_ch_i,
    input  logic [2:0]                   wr_sel_i,
    input  logic [COEF_W-1:0]            wr_data_i,
    input  logic [CH_W-1:0]              rd_ch_i,
    output logic [NUM_COEF*COEF_W-1:0]   rd_coef_o
);

    logic [COEF_W-1:0] coef_q [NCH][NUM_COEF];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NUM_COEF; k++) begin
                    coef_q[c][k] <= (k == int'(B0)) ? COEF_W'(1 << FRAC) : '0;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NUM_COEF; k++) begin
                    if (we_i && 32'(wr_ch_i) == c && 32'(wr_sel_i) == k) begin
                        coef_q[c][k] <= wr_data_i;
                    end
                end
            end
        end
    end

    // Channels outside the bank read as all-zero coefficients, giving y = 0.
    always_comb begin
        rd_coef_o = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(rd_ch_i) == c) begin
                for (int k = 0; k < NUM_COEF; k++) begin
                    rd_coef_o[k*COEF_W +: COEF_W] = coef_q[c][k];
                end
            end
        end
    end

endmodule

// File: rtl/biquad_mc.sv
// Multichannel direct-form-I biquad: one shared multiplier walks the five
// taps of a sample over five cycles, with per-channel coefficients and history.
module biquad_mc
    import filter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = FRAC_DEFAULT,
    parameter int NCH    = 4,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] y,
    input  logic              coef_we,
    input  logic [CH_W-1:0]   coef_ch,
    input  logic [2:0]        coef_sel,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              clr,
    input  logic [CH_W-1:0]   clr_ch
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ACC_GUARD;

    state_e                        state_q, state_d;
    logic                          accept;
    logic [NUM_COEF*COEF_W-1:0]    bank_rd;
    logic [NUM_COEF*COEF_W-1:0]    coef_q;
    logic [CH_W-1:0]               ch_q;
    logic signed [DATA_W-1:0]      x_q, x1_s_q, x2_s_q, y1_s_q, y2_s_q;
    logic signed [DATA_W-1:0]      snap_x1, snap_x2, snap_y1, snap_y2;
    logic                          clr_hit_q;
    logic signed [ACC_W-1:0]       acc_q, acc_d, acc_base, shifted;
    logic signed [COEF_W-1:0]      coef_op;
    logic signed [DATA_W-1:0]      data_op;
    logic signed [PROD_W-1:0]      prod;
    logic                          sub;
    logic signed [63:0]            sat64;
    logic signed [DATA_W-1:0]      y_sat;
    logic                          out_valid_q;
    logic [CH_W-1:0]               out_ch_q;
    logic [DATA_W-1:0]             y_q;
    logic signed [DATA_W-1:0]      hx1_q [NCH];
    logic signed [DATA_W-1:0]      hx2_q [NCH];
    logic signed [DATA_W-1:0]      hy1_q [NCH];
    logic signed [DATA_W-1:0]      hy2_q [NCH];

    filter_coef_bank #(
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .NCH    (NCH),
        .CH_W   (CH_W)
    ) u_coef_bank (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .we_i      (coef_we),
        .wr_ch_i   (coef_ch),
        .wr_sel_i  (coef_sel),
        .wr_data_i (coef_data),
        .rd_ch_i   (in_ch),
        .rd_coef_o (bank_rd)
    );

    // Valid/ready: a sample transfers on any edge where in_valid and in_ready
    // are both high; in_ready is high only in IDLE and the requester holds.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_MAC0;
            end
            ST_MAC0: state_d = ST_MAC1;
            ST_MAC1: state_d = ST_MAC2;
            ST_MAC2: state_d = ST_MAC3;
            ST_MAC3: state_d = ST_MAC4;
            ST_MAC4: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        snap_x1 = '0;
        snap_x2 = '0;
        snap_y1 = '0;
        snap_y2 = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(in_ch) == c) begin
                snap_x1 = hx1_q[c];
                snap_x2 = hx2_q[c];
                snap_y1 = hy1_q[c];
                snap_y2 = hy2_q[c];
            end
        end
    end

    always_comb begin
        coef_op = '0;
        data_op = '0;
        sub     = 1'b0;
        case (state_q)
            ST_MAC0: begin coef_op = coef_q[int'(B0)*COEF_W +: COEF_W]; data_op = x_q;    end
            ST_MAC1: begin coef_op = coef_q[int'(B1)*COEF_W +: COEF_W]; data_op = x1_s_q; end
            ST_MAC2: begin coef_op = coef_q[int'(B2)*COEF_W +: COEF_W]; data_op = x2_s_q; end
            ST_MAC3: begin coef_op = coef_q[int'(A1)*COEF_W +: COEF_W]; data_op = y1_s_q; sub = 1'b1; end
            ST_MAC4: begin coef_op = coef_q[int'(A2)*COEF_W +: COEF_W]; data_op = y2_s_q; sub = 1'b1; end
            default: ;
        endcase
        prod     = coef_op * data_op;
        acc_base = (state_q == ST_MAC0) ? '0 : acc_q;
        acc_d    = sub ? acc_base - ACC_W'(prod) : acc_base + ACC_W'(prod);
        shifted  = acc_d >>> FRAC;
        sat64    = saturate(64'(shifted), DATA_W);
        y_sat    = DATA_W'(sat64);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            coef_q      <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            x1_s_q      <= '0;
            x2_s_q      <= '0;
            y1_s_q      <= '0;
            y2_s_q      <= '0;
            clr_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_q == ST_MAC4);
            if (state_q == ST_MAC4) begin
                y_q      <= y_sat;
                out_ch_q <= ch_q;
            end
            if (state_q != ST_IDLE && state_q != ST_DONE) acc_q <= acc_d;
            // History is snapshotted with the coefficients so a clear mid-flight
            // cannot change the sample being computed.
            if (accept) begin
                x_q       <= x;
                ch_q      <= in_ch;
                coef_q    <= bank_rd;
                x1_s_q    <= snap_x1;
                x2_s_q    <= snap_x2;
                y1_s_q    <= snap_y1;
                y2_s_q    <= snap_y2;
                clr_hit_q <= clr && (clr_ch == in_ch);
            end else if (state_q != ST_IDLE && clr && clr_ch == ch_q) begin
                clr_hit_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                hx1_q[c] <= '0;
                hx2_q[c] <= '0;
                hy1_q[c] <= '0;
                hy2_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clr && 32'(clr_ch) == c) begin
                    hx1_q[c] <= '0;
                    hx2_q[c] <= '0;
                    hy1_q[c] <= '0;
                    hy2_q[c] <= '0;
                end else if (state_q == ST_DONE && !clr_hit_q && 32'(ch_q) == c) begin
                    hx2_q[c] <= hx1_q[c];
                    hx1_q[c] <= x_q;
                    hy2_q[c] <= hy1_q[c];
                    hy1_q[c] <= y_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y         = y_q;

endmodule

// File: tb/tb_biquad_mc.sv
// Directed bench for biquad_mc: latency, FIR/IIR taps, saturation,
// channel isolation, history clear and mid-operation reset.
module tb_biquad_mc;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [15:0] x = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] y;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_ch = '0;
    logic [2:0]  coef_sel = '0;
    logic [15:0] coef_data = '0;
    logic        clr = 1'b0;
    logic [1:0]  clr_ch = '0;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    biquad_mc dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .x         (x),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .y         (y),
        .coef_we   (coef_we),
        .coef_ch   (coef_ch),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .clr       (clr),
        .clr_ch    (clr_ch)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic write_coef(input logic [1:0] ch, input logic [2:0] sel, input logic [15:0] d);
        @(negedge Clk);
        coef_we = 1'b1; coef_ch = ch; coef_sel = sel; coef_data = d;
        @(negedge Clk);
        coef_we = 1'b0;
    endtask

    task automatic clear_ch(input logic [1:0] ch);
        @(negedge Clk);
        clr = 1'b1; clr_ch = ch;
        @(negedge Clk);
        clr = 1'b0;
    endtask

    // Sends one sample; clr_at > 0 pulses clr for cch at that cycle after accept.
    task automatic send(input logic [1:0] ch, input logic [15:0] xv, input int clr_at,
                        input logic [1:0] cch, output logic [15:0] yv,
                        output logic [1:0] och, output int lat, output bit seen);
        int n = 0;
        @(negedge Clk);
        while (!in_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        in_valid = 1'b1; in_ch = ch; x = xv;
        @(negedge Clk);
        in_valid = 1'b0;
        seen = 1'b0; lat = 0; yv = '0; och = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge Clk);
            if (i == clr_at) begin
                clr = 1'b1; clr_ch = cch;
            end else begin
                clr = 1'b0;
            end
            if (out_valid && !seen) begin
                seen = 1'b1; lat = i; yv = y; och = out_ch;
            end
            if (seen) break;
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (y !== 16'h0000) begin failures++; $display("FAIL reset_y got=%h exp=0000", y); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    endtask

    task automatic test_passthrough();
        logic [6:0]  rdy;
        logic [6:0]  vld;
        logic [15:0] yv;
        logic [1:0]  och;
        rdy = '0; vld = '0; yv = '0; och = 2'd3;
        @(negedge Clk);
        in_valid = 1'b1; in_ch = 2'd0; x = 16'h1234;
        @(negedge Clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) @(negedge Clk);
            rdy[i-1] = in_ready;
            vld[i-1] = out_valid;
            if (out_valid) begin yv = y; och = out_ch; end
        end
        checks++; if (rdy !== 7'b1000000) begin failures++; $display("FAIL pass_ready_window got=%b exp=1000000", rdy); end
        checks++; if (vld !== 7'b0100000) begin failures++; $display("FAIL pass_valid_timing got=%b exp=0100000", vld); end
        checks++; if (yv !== 16'h1234) begin failures++; $display("FAIL pass_y got=%h exp=1234", yv); end
        checks++; if (och !== 2'd0) begin failures++; $display("FAIL pass_out_ch got=%0d exp=0", och); end
    endtask

    task automatic test_fir();
        logic [15:0] exp_y [3];
        logic [15:0] xin [3];
        logic [15:0] yv;
        logic [1:0]  och;
        int lat;
        bit seen;
        exp_y[0] = 16'd500; exp_y[1] = 16'd500; exp_y[2] = 16'd0;
        xin[0] = 16'd1000; xin[1] = 16'd0; xin[2] = 16'd0;
        write_coef(2'd1, 3'd0, 16'h2000);
        write_coef(2'd1, 3'd1, 16'h2000);
        for (int i = 0; i < 3; i++) begin
            send(2'd1, xin[i], 0, 2'd0, yv, och, lat, seen);
            checks++;
            if (!seen || yv !== exp_y[i] || och !== 2'd1) begin
                failures++;
                $display("FAIL fir_y[%0d] got=%0d ch=%0d seen=%0b exp=%0d ch=1", i, $signed(yv), och, seen, $signed(exp_y[i]));
            end
        end
        checks++; if (lat !== 6) begin failures++; $display("FAIL fir_latency got=%0d exp=6", lat); end
    endtask

    task automatic test_iir();
        logic [15:0] exp_y [3];
        logic [15:0] xin [3];
        logic [15:0] yv;
        logic [1:0]  och;
        int lat;
        bit seen;
        exp_y[0] = 16'd1000; exp_y[1] = 16'd500; exp_y[2] = 16'd250;
        xin[0] = 16'd1000; xin[1] = 16'd0; xin[2] = 16'd0;
        write_coef(2'd2, 3'd0, 16'h4000);
        write_coef(2'd2, 3'd3, 16'hE000);
        for (int i = 0; i < 3; i++) begin
            send(2'd2, xin[i], 0, 2'd0, yv, och, lat, seen);
            checks++;
            if (!seen || yv !== exp_y[i]) begin
                failures++;
                $display("FAIL iir_y[%0d] got=%0d seen=%0b exp=%0d", i, $signed(yv), seen, $signed(exp_y[i]));
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] yv;
        logic [1:0]  och;
        int lat;
        bit seen;
        write_coef(2'd3, 3'd0, 16'h7FFF);
        send(2'd3, 16'h7000, 0, 2'd0, yv, och, lat, seen);
        checks++; if (!seen || yv !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h seen=%0b exp=7fff", yv, seen); end
        send(2'd3, 16'h9000, 0, 2'd0, yv, och, lat, seen);
        checks++; if (!seen || yv !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h seen=%0b exp=8000", yv, seen); end
    endtask

    task automatic test_interleave_clear();
        logic [1:0]  chs [5];
        logic [15:0] xin [5];
        logic [15:0] exp_y [5];
        int          clr_at [5];
        logic [15:0] yv;
        logic [1:0]  och;
        int lat;
        bit seen;
        chs[0] = 2'd2; xin[0] = 16'd1000;  exp_y[0] = 16'd1000;  clr_at[0] = 0;
        chs[1] = 2'd0; xin[1] = 16'd100;   exp_y[1] = 16'd100;   clr_at[1] = 0;
        chs[2] = 2'd2; xin[2] = 16'd0;     exp_y[2] = 16'd500;   clr_at[2] = 3;
        chs[3] = 2'd0; xin[3] = 16'hFFFB;  exp_y[3] = 16'hFFFB;  clr_at[3] = 0;
        chs[4] = 2'd2; xin[4] = 16'd0;     exp_y[4] = 16'd0;     clr_at[4] = 0;
        clear_ch(2'd2);
        for (int i = 0; i < 5; i++) begin
            send(chs[i], xin[i], clr_at[i], 2'd2, yv, och, lat, seen);
            checks++;
            if (!seen || yv !== exp_y[i] || och !== chs[i]) begin
                failures++;
                $display("FAIL mix_y[%0d] got=%0d ch=%0d seen=%0b exp=%0d ch=%0d", i, $signed(yv), och, seen, $signed(exp_y[i]), chs[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] yv;
        logic [1:0]  och;
        int lat;
        bit seen;
        bit saw_valid;
        saw_valid = 1'b0;
        write_coef(2'd1, 3'd0, 16'h1000);
        @(negedge Clk);
        in_valid = 1'b1; in_ch = 2'd1; x = 16'd500;
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            saw_valid |= out_valid;
        end
        Reset_n = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            saw_valid |= out_valid;
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid got=%b exp=0", saw_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        send(2'd1, 16'd77, 0, 2'd0, yv, och, lat, seen);
        checks++; if (!seen || yv !== 16'd77) begin failures++; $display("FAIL rst_mid_pass got=%0d seen=%0b exp=77", yv, seen); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=6", lat); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fir();
        test_iir();
        test_saturation();
        test_interleave_clear();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
